multi_channel_accum: RTL and testbench
======================================

Name: multi_channel_accum

Overview:
Parametrised multi-channel successor to the single 32-bit accumulator. It keeps CHANNELS independent WIDTH-bit accumulators, fed through a valid/ready input stream, with per-channel sticky overflow flags. A dump state machine streams every channel out over a valid/ready output port and clears each channel as it is sent. It sits between a sample source and a checker/logger in simulation-driven test harnesses.

Parameters:
- WIDTH, 32, accumulator and data width in bits (>= 2).
- CHANNELS, 4, number of independent accumulators (>= 2).
- CH_BITS, $clog2(CHANNELS), channel index width; derived, not overridden.

Ports:
- clock  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- in_channel  input  CH_BITS  target channel; values >= CHANNELS are dropped.
- in_data  input  WIDTH  unsigned addend.
- in_clear  input  1  with an accepted sample, load in_data instead of adding it.
- dump_req  input  1  single-cycle pulse; starts a dump.
- busy  output  1  high while a dump is in progress.
- out_valid  output  1  dump beat valid.
- out_ready  input  1  consumer accepts a dump beat.
- out_channel  output  CH_BITS  channel of the current beat.
- out_data  output  WIDTH  accumulator value of the current beat.
- out_ovf  output  1  sticky overflow flag of the current beat.
- ovf_any  output  1  OR of all sticky overflow flags.

Behaviour:
- Reset: all accumulators 0, all ovf flags 0; FSM in IDLE; busy=0, out_valid=0, out_channel=0, out_data=0, out_ovf=0, ovf_any=0. in_ready is 1 in the first cycle after reset. A reset in the middle of a dump aborts the dump and applies the same reset values.
- Accept: a sample is accepted when in_valid && in_ready. The accumulator updates on that clock edge and is visible in the dump one cycle later.
- Arithmetic: acc_next = in_clear ? in_data : acc + in_data, computed at WIDTH+1 bits.
  - If the carry bit is set, ovf[ch] <= 1. The flag is sticky and is cleared only by reset or by a dump.
  - Without the optional feature the result wraps modulo 2^WIDTH.
  - in_clear never sets ovf.
- Out-of-range channel: the sample is still accepted (handshake completes) but no state changes.
- FSM states:
  - IDLE: in_ready=1. When dump_req is seen, go to LOAD. If dump_req and an accepted sample arrive in the same cycle, the sample is applied first and is included in the dump.
  - LOAD: in_ready=0. Register out_data=acc[idx], out_ovf=ovf[idx], out_channel=idx. Set out_valid=1 and go to SEND.
  - SEND: in_ready=0. Hold out_* stable while out_valid && !out_ready. When out_valid && out_ready:
    - clear acc[idx] and ovf[idx] to 0 and drop out_valid;
    - if idx == CHANNELS-1, go to IDLE;
    - otherwise idx++ and go to LOAD.
- Dump timing: 2 cycles per channel minimum (LOAD then SEND). busy=1 in LOAD and SEND. dump_req is ignored while busy.
- ovf_any is registered and reflects the flags after the current edge's update.

Optional Feature:
- MULTI_CHANNEL_ACCUM_SAT_EN defined: on carry out, the result saturates to 2^WIDTH-1 and ovf is still set. A saturated accumulator stays saturated on further adds; in_clear still loads in_data.
- Not defined: the result wraps modulo 2^WIDTH, as described in Behaviour.

Test Plan:
- Reset, then send in_data=1..256 on channel 0 with in_valid held high, then dump_req with out_ready=1. Required: channel 0 beat out_data=32896, out_ovf=0; channels 1-3 out_data=0; busy falls after 8 cycles.
- Interleave channels (ch0 +5, ch1 +7, ch2 +9, ch3 +11, repeated 10 times), then dump with out_ready held low for 3 cycles on every beat. Required: beats are 50, 70, 90, 110 in channel order; out_* stable while stalled; a second dump then returns all zeros.
- WIDTH=8: ch1 +200 then +100. Required: out_data=44, out_ovf=1, ovf_any=1 (wrap). With MULTI_CHANNEL_ACCUM_SAT_EN: out_data=255, out_ovf=1. After the dump, ovf_any=0.
- in_clear: ch2 +10, then in_data=3 with in_clear=1, then +4. Required: dump shows ch2=7. A sample with in_channel=5 (CHANNELS=4) is accepted and leaves all channels unchanged.
- Same cycle: dump_req together with a ch0 +9 sample in IDLE. Required: ch0 beat includes the +9; in_ready=0 during the dump; an in_valid held high during the dump is accepted only after return to IDLE.
- Reset asserted during the SEND of channel 1. Required: next cycle out_valid=0, busy=0, all accumulators 0; a fresh dump returns zeros.

Source files
------------

// File: rtl/multi_channel_accum_if.sv
// Stream bundle for multi_channel_accum: sample input stream and dump output stream.
interface multi_channel_accum_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int CH_BITS = $clog2(CHANNELS);

  logic               in_valid;
  logic               in_ready;
  logic [CH_BITS-1:0] in_channel;
  logic [WIDTH-1:0]   in_data;
  logic               in_clear;
  logic               out_valid;
  logic               out_ready;
  logic [CH_BITS-1:0] out_channel;
  logic [WIDTH-1:0]   out_data;
  logic               out_ovf;

  modport master (
    output in_valid, in_channel, in_data, in_clear, out_ready,
    input  in_ready, out_valid, out_channel, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_channel, in_data, in_clear, out_ready,
    output in_ready, out_valid, out_channel, out_data, out_ovf
  );
endinterface

// File: rtl/multi_channel_accum.sv
// CHANNELS independent WIDTH-bit accumulators with sticky overflow flags and a
// dump engine that streams and clears every channel in order.
// Optional: define MULTI_CHANNEL_ACCUM_SAT_EN to saturate instead of wrap.
module multi_channel_accum #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  multi_channel_accum_if.slave  bus,
  input  logic                  dump_req,
  output logic                  busy,
  output logic                  ovf_any
);
  localparam int CH_BITS = $clog2(CHANNELS);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc [CHANNELS];
  logic [CHANNELS-1:0] ovf, ovf_next;
  logic [CH_BITS-1:0] idx;
  logic [CH_BITS-1:0] sel;
  logic               accept, in_range, carry, beat_done, last_ch;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_new;
  logic               out_valid_r, out_ovf_r;
  logic [CH_BITS-1:0] out_channel_r;
  logic [WIDTH-1:0]   out_data_r;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.out_channel = out_channel_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_ovf     = out_ovf_r;
  assign busy            = (state != IDLE);

  // Sample datapath: range check, WIDTH+1-bit add, wrap or saturate.
  always_comb begin
    accept    = bus.in_valid && (state == IDLE);
    in_range  = ({1'b0, bus.in_channel} < (CH_BITS + 1)'(CHANNELS));
    sel       = in_range ? bus.in_channel : '0;
    sum       = {1'b0, acc[sel]} + {1'b0, bus.in_data};
    carry     = !bus.in_clear && sum[WIDTH];
    if (bus.in_clear) begin
      acc_new = bus.in_data;
    end else begin
`ifdef MULTI_CHANNEL_ACCUM_SAT_EN
      acc_new = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
      acc_new = sum[WIDTH-1:0];
`endif
    end
    beat_done = (state == SEND) && out_valid_r && bus.out_ready;
    last_ch   = (idx == CH_BITS'(CHANNELS - 1));
  end

  // Overflow flags after this edge: set on carry, cleared when the channel is dumped.
  always_comb begin
    ovf_next = ovf;
    if (accept && in_range && carry) ovf_next[sel] = 1'b1;
    if (beat_done)                   ovf_next[idx] = 1'b0;
  end

  // Dump FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dump_req) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (beat_done) state_next = last_ch ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Dump FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Accumulators, flags, channel index and registered dump beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) acc[i] <= '0;
      ovf           <= '0;
      ovf_any       <= 1'b0;
      idx           <= '0;
      out_valid_r   <= 1'b0;
      out_channel_r <= '0;
      out_data_r    <= '0;
      out_ovf_r     <= 1'b0;
    end else begin
      ovf     <= ovf_next;
      ovf_any <= |ovf_next;
      case (state)
        IDLE: begin
          if (accept && in_range) acc[sel] <= acc_new;
          if (dump_req) idx <= '0;
        end
        LOAD: begin
          out_data_r    <= acc[idx];
          out_ovf_r     <= ovf[idx];
          out_channel_r <= idx;
          out_valid_r   <= 1'b1;
        end
        SEND: begin
          if (beat_done) begin
            acc[idx]    <= '0;
            out_valid_r <= 1'b0;
            if (!last_ch) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_channel_accum.sv
// Bench: dut 0 is WIDTH=32/CHANNELS=4, dut 1 is WIDTH=8/CHANNELS=3 (wrap and
// out-of-range channel cases). Expected beats come from a per-channel model.
module tb_multi_channel_accum;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic [1:0]       in_valid, in_clear, out_ready, dump_req;
  logic [1:0][2:0]  in_channel;
  logic [1:0][31:0] in_data;
  logic [1:0]       in_ready, out_valid, out_ovf, busy, ovf_any;
  logic [1:0][1:0]  out_channel;
  logic [1:0][31:0] out_data;

  multi_channel_accum_if #(.WIDTH(32), .CHANNELS(4)) bus_a ();
  multi_channel_accum_if #(.WIDTH(8),  .CHANNELS(3)) bus_b ();

  assign bus_a.in_valid   = in_valid[0];
  assign bus_a.in_channel = in_channel[0][1:0];
  assign bus_a.in_data    = in_data[0];
  assign bus_a.in_clear   = in_clear[0];
  assign bus_a.out_ready  = out_ready[0];
  assign in_ready[0]      = bus_a.in_ready;
  assign out_valid[0]     = bus_a.out_valid;
  assign out_channel[0]   = bus_a.out_channel;
  assign out_data[0]      = bus_a.out_data;
  assign out_ovf[0]       = bus_a.out_ovf;

  assign bus_b.in_valid   = in_valid[1];
  assign bus_b.in_channel = in_channel[1][1:0];
  assign bus_b.in_data    = in_data[1][7:0];
  assign bus_b.in_clear   = in_clear[1];
  assign bus_b.out_ready  = out_ready[1];
  assign in_ready[1]      = bus_b.in_ready;
  assign out_valid[1]     = bus_b.out_valid;
  assign out_channel[1]   = bus_b.out_channel;
  assign out_data[1]      = {24'd0, bus_b.out_data};
  assign out_ovf[1]       = bus_b.out_ovf;

  logic busy_a, busy_b, ovf_any_a, ovf_any_b;
  assign busy[0]    = busy_a;
  assign busy[1]    = busy_b;
  assign ovf_any[0] = ovf_any_a;
  assign ovf_any[1] = ovf_any_b;

  multi_channel_accum #(.WIDTH(32), .CHANNELS(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave),
    .dump_req(dump_req[0]), .busy(busy_a), .ovf_any(ovf_any_a)
  );

  multi_channel_accum #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave),
    .dump_req(dump_req[1]), .busy(busy_b), .ovf_any(ovf_any_b)
  );

  longint unsigned m_acc [2][4];
  bit              m_ovf [2][4];
  int              nch [2] = '{4, 3};
  int              wid [2] = '{32, 8};
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input int d, input int ch, input longint unsigned data, input bit clr);
    longint unsigned lim, s, v;
    lim = 64'd1 << wid[d];
    v   = data & (lim - 1);
    if (ch < nch[d]) begin
      if (clr) m_acc[d][ch] = v;
      else begin
        s = m_acc[d][ch] + v;
        if (s >= lim) begin
          m_ovf[d][ch] = 1'b1;
`ifdef MULTI_CHANNEL_ACCUM_SAT_EN
          m_acc[d][ch] = lim - 1;
`else
          m_acc[d][ch] = s - lim;
`endif
        end else m_acc[d][ch] = s;
      end
    end
  endtask

  function automatic bit model_any(input int d);
    bit a = 1'b0;
    for (int c = 0; c < 4; c++) a |= m_ovf[d][c];
    return a;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_acc[d][c] = 0;
        m_ovf[d][c] = 1'b0;
      end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One accepted sample in IDLE; in_valid is left high for back-to-back use.
  task automatic send(input int d, input int ch, input logic [31:0] data, input bit clr);
    in_valid[d]   = 1'b1;
    in_channel[d] = 3'(ch);
    in_data[d]    = data;
    in_clear[d]   = clr;
    chk("in_ready_idle", in_ready[d], 1);
    cycle();
    model_apply(d, ch, data, clr);
  endtask

  // Full dump with `stall` cycles of out_ready low on every beat.
  task automatic dump(input int d, input int stall, output int bc);
    int n;
    logic [35:0] cap;
    bc = 0;
    chk("ovf_any_pre", ovf_any[d], model_any(d));
    dump_req[d]  = 1'b1;
    out_ready[d] = (stall == 0);
    cycle();
    dump_req[d] = 1'b0;
    for (int ch = 0; ch < nch[d]; ch++) begin
      n = 0;
      while (!out_valid[d] && n < 10) begin
        if (busy[d]) bc++;
        cycle();
        n++;
      end
      chk("beat_valid", out_valid[d], 1);
      chk("in_ready_busy", in_ready[d], 0);
      chk("beat_channel", out_channel[d], ch);
      chk("beat_data", out_data[d], m_acc[d][ch]);
      chk("beat_ovf", out_ovf[d], m_ovf[d][ch]);
      cap = {out_valid[d], out_channel[d], out_ovf[d], out_data[d]};
      for (int s = 0; s < stall; s++) begin
        bc++;
        cycle();
        chk("stall_hold", {out_valid[d], out_channel[d], out_ovf[d], out_data[d]}, cap);
      end
      out_ready[d] = 1'b1;
      bc++;
      cycle();
      out_ready[d] = (stall == 0);
      m_acc[d][ch] = 0;
      m_ovf[d][ch] = 1'b0;
    end
    n = 0;
    while (busy[d] && n < 10) begin
      bc++;
      cycle();
      n++;
    end
    out_ready[d] = 1'b0;
    chk("busy_end", busy[d], 0);
    chk("ovf_any_post", ovf_any[d], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, n;
    in_valid = '0; in_clear = '0; out_ready = '0; dump_req = '0;
    in_channel = '0; in_data = '0;
    model_clear();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    cycle();

    // Reset values on both instances.
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_out_valid", out_valid[d], 0);
      chk("rst_out_channel", out_channel[d], 0);
      chk("rst_out_data", out_data[d], 0);
      chk("rst_out_ovf", out_ovf[d], 0);
      chk("rst_ovf_any", ovf_any[d], 0);
      chk("rst_in_ready", in_ready[d], 1);
    end

    // 1..256 on channel 0, back to back, then a full-speed dump.
    for (int i = 1; i <= 256; i++) send(0, 0, 32'(i), 1'b0);
    in_valid[0] = 1'b0;
    dump(0, 0, bc);
    chk("busy_cycles", bc, 8);

    // Interleaved channels, stalled dump, then a dump of cleared channels.
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 4; c++) send(0, c, 32'(5 + 2 * c), 1'b0);
    in_valid[0] = 1'b0;
    dump(0, 3, bc);
    dump(0, 0, bc);

    // 8-bit overflow on channel 1.
    send(1, 1, 200, 1'b0);
    send(1, 1, 100, 1'b0);
    in_valid[1] = 1'b0;
    cycle();
    chk("ovf_any_b", ovf_any[1], 1);
    dump(1, 0, bc);

    // in_clear load, and an out-of-range channel on the 3-channel instance.
    send(0, 2, 10, 1'b0);
    send(0, 2, 3, 1'b1);
    send(0, 2, 4, 1'b0);
    in_valid[0] = 1'b0;
    dump(0, 1, bc);
    send(1, 1, 50, 1'b0);
    send(1, 3, 77, 1'b0);
    in_valid[1] = 1'b0;
    dump(1, 0, bc);

    // dump_req with a same-cycle sample; sample held valid during the dump.
    in_valid[0] = 1'b1; in_channel[0] = 3'd0; in_data[0] = 32'd9; in_clear[0] = 1'b0;
    model_apply(0, 0, 9, 1'b0);
    dump(0, 0, bc);
    chk("held_ready_after", in_ready[0], 1);
    cycle();
    model_apply(0, 0, 9, 1'b0);
    in_valid[0] = 1'b0;
    dump(0, 0, bc);

    // Randomized rounds on both instances, including wraps and clears.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 30; k++)
        send(0, int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
      in_valid[0] = 1'b0;
      dump(0, int'($urandom_range(0, 2)), bc);
      for (int k = 0; k < 20; k++)
        send(1, int'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      in_valid[1] = 1'b0;
      dump(1, int'($urandom_range(0, 2)), bc);
    end

    // Reset during the SEND of channel 1.
    for (int c = 0; c < 4; c++) send(0, c, 32'(100 + c), 1'b0);
    in_valid[0] = 1'b0;
    dump_req[0] = 1'b1;
    out_ready[0] = 1'b1;
    cycle();
    dump_req[0] = 1'b0;
    n = 0;
    while (!(out_valid[0] && out_channel[0] == 2'd1) && n < 20) begin
      cycle();
      n++;
    end
    chk("reach_send_ch1", out_valid[0] && out_channel[0] == 2'd1, 1);
    reset = 1'b1;
    out_ready[0] = 1'b0;
    cycle();
    reset = 1'b0;
    model_clear();
    chk("mid_rst_out_valid", out_valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_ovf_any", ovf_any[0], 0);
    cycle();
    chk("mid_rst_in_ready", in_ready[0], 1);
    dump(0, 0, bc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
